// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the iterative multiply/divide unit
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bit 0 of the opcode selects the unsigned flavour, bit 1 selects divide.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add or restoring-subtract iteration on the {rem, acc} pair
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // Multiply keeps the multiplier in acc and shifts the product in from the top;
  // divide shifts the dividend out of acc into rem and collects quotient bits in acc.
  always_comb begin
    rem_o   = rem_i;
    acc_o   = acc_i;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    if (is_div) begin
      shifted = {rem_i, acc_i[WIDTH-1]};
      diff    = shifted[WIDTH-1:0] - opb_i;
      if (shifted >= {1'b0, opb_i}) begin
        rem_o = diff;
        acc_o = {acc_i[WIDTH-2:0], 1'b1};
      end else begin
        rem_o = shifted[WIDTH-1:0];
        acc_o = {acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, rem_i} + (acc_i[0] ? {1'b0, opb_i} : {(WIDTH+1){1'b0}});
      rem_o = sum[WIDTH:1];
      acc_o = {sum[0], acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             wHi,
  input  logic             wLo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   step_rem, step_acc;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               accept, last_iter;
  logic [2*WIDTH-1:0] prod_raw, prod;
  logic [WIDTH-1:0]   quo, rmd;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .rem_i  (rem_q),
    .acc_i  (acc_q),
    .opb_i  (opb_q),
    .rem_o  (step_rem),
    .acc_o  (step_acc)
  );

  // Operands iterate as magnitudes; |MIN| fits because the datapath is unsigned.
  always_comb begin
    sign_a    = op_is_signed(op) & srcA[WIDTH-1];
    sign_b    = op_is_signed(op) & srcB[WIDTH-1];
    mag_a     = sign_a ? -srcA : srcA;
    mag_b     = sign_b ? -srcB : srcB;
    accept    = start && (state_q != ST_RUN);
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    prod_raw = {step_rem, step_acc};
    prod     = neg_q ? -prod_raw : prod_raw;
    quo      = div0_q ? {WIDTH{1'b1}} : (neg_q ? -step_acc : step_acc);
    rmd      = rem_neg_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_RUN: begin
        rem_d = step_rem;
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = ST_DONE;
          if (is_div_q) begin
            hi_d = rmd;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: begin
        // A start in the same cycle as MTHI/MTLO takes priority and drops the writes.
        if (accept) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          rem_d     = '0;
          acc_d     = mag_a;
          opb_d     = mag_b;
          is_div_d  = op_is_div(op);
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
          div0_d    = op_is_div(op) && (srcB == '0);
        end else begin
          state_d = ST_IDLE;
          if (wHi) hi_d = srcA;
          if (wLo) lo_d = srcA;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        wHi = 1'b0;
  logic        wLo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  muldiv_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .srcA(srcA), .srcB(srcB), .wHi(wHi), .wLo(wLo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      OP_MULT:  return sa * sb;
      OP_MULTU: return {32'b0, a} * {32'b0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    exp_q.push_back(expv);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic collect(output int cycles, output logic [31:0] h, output logic [31:0] l,
                         output logic d);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clock);
    end
    h = hi;
    l = lo;
    d = done;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_table(input string name, input logic [1:0] ops[], input logic [31:0] as[],
                            input logic [31:0] bs[], input logic [63:0] exps[]);
    int c;
    logic [31:0] h, l;
    logic d;
    logic [63:0] e;
    for (int i = 0; i < ops.size(); i++) begin
      launch(ops[i], as[i], bs[i], exps[i]);
      collect(c, h, l, d);
      e = exp_q.pop_front();
      checks++; if (c != 32) begin errors++; $display("FAIL %s[%0d] busy_cycles: got %0d want 32", name, i, c); end
      checks++; if (d !== 1'b1) begin errors++; $display("FAIL %s[%0d] done: got %b want 1", name, i, d); end
      checks++; if (h !== e[63:32]) begin errors++; $display("FAIL %s[%0d] hi: got %h want %h", name, i, h, e[63:32]); end
      checks++; if (l !== e[31:0]) begin errors++; $display("FAIL %s[%0d] lo: got %h want %h", name, i, l, e[31:0]); end
    end
  endtask

  task automatic test_mult;
    logic [1:0]  o[] = '{OP_MULTU, OP_MULT, OP_MULT, OP_MULTU, OP_MULT};
    logic [31:0] a[] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'd6, 32'd5};
    logic [31:0] b[] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd7, 32'hFFFFFFFF};
    logic [63:0] e[] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000,
                         64'h00000000_0000002A, 64'hFFFFFFFF_FFFFFFFB};
    test_table("mult", o, a, b, e);
  endtask

  task automatic test_div;
    logic [1:0]  o[] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] a[] = '{32'hFFFFFFF9, 32'd100, 32'h12345678, 32'h80000000, 32'd5, 32'hFFFFFFF9};
    logic [31:0] b[] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [63:0] e[] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000002_0000000E, 64'h12345678_FFFFFFFF,
                         64'h00000000_80000000, 64'h00000005_FFFFFFFF, 64'hFFFFFFF9_FFFFFFFF};
    test_table("div", o, a, b, e);
  endtask

  task automatic test_back_to_back;
    logic [1:0]  o[];
    logic [31:0] a[], b[];
    logic [63:0] e[];
    o = new[8]; a = new[8]; b = new[8]; e = new[8];
    for (int i = 0; i < 8; i++) begin
      o[i] = 2'($urandom_range(0, 3));
      a[i] = $urandom;
      b[i] = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      e[i] = model(o[i], a[i], b[i]);
    end
    test_table("random", o, a, b, e);
  endtask

  task automatic test_control;
    int c;
    logic [31:0] h, l;
    logic d;
    logic [63:0] e;
    launch(OP_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E);
    repeat (3) @(negedge clock);
    start = 1'b1; op = OP_MULTU; srcA = 32'h1; srcB = 32'h1; wHi = 1'b1;
    @(negedge clock);
    start = 1'b0; wHi = 1'b0;
    collect(c, h, l, d);
    e = exp_q.pop_front();
    checks++; if (c != 28) begin errors++; $display("FAIL ignore_start cycles: got %0d want 28", c); end
    checks++; if (d !== 1'b1) begin errors++; $display("FAIL ignore_start done: got %b want 1", d); end
    checks++; if (h !== e[63:32]) begin errors++; $display("FAIL ignore_whi hi: got %h want %h", h, e[63:32]); end
    checks++; if (l !== e[31:0]) begin errors++; $display("FAIL ignore_start lo: got %h want %h", l, e[31:0]); end
    wHi = 1'b1; srcA = 32'h0BADF00D;
    @(negedge clock);
    wHi = 1'b0;
    checks++; if (hi !== 32'h0BADF00D) begin errors++; $display("FAIL mthi_in_done hi: got %h want 0badf00d", hi); end
    checks++; if (lo !== 32'h0000000E) begin errors++; $display("FAIL mthi_in_done lo: got %h want 0000000e", lo); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
    wLo = 1'b1; srcA = 32'hCAFEBABE;
    @(negedge clock);
    wLo = 1'b0;
    checks++; if (lo !== 32'hCAFEBABE) begin errors++; $display("FAIL mtlo lo: got %h want cafebabe", lo); end
    checks++; if (hi !== 32'h0BADF00D) begin errors++; $display("FAIL mtlo hi: got %h want 0badf00d", hi); end
    wHi = 1'b1; wLo = 1'b1; srcA = 32'h11112222;
    @(negedge clock);
    wHi = 1'b0; wLo = 1'b0;
    checks++; if ({hi, lo} !== 64'h11112222_11112222) begin errors++; $display("FAIL mthi_mtlo: got %h%h want 1111222211112222", hi, lo); end
    wHi = 1'b1; wLo = 1'b1;
    launch(OP_MULTU, 32'd3, 32'd5, 64'h00000000_0000000F);
    wHi = 1'b0; wLo = 1'b0;
    checks++; if ({hi, lo} !== 64'h11112222_11112222) begin errors++; $display("FAIL start_wins_hilo: got %h%h want 1111222211112222", hi, lo); end
    collect(c, h, l, d);
    e = exp_q.pop_front();
    checks++; if ({h, l} !== e) begin errors++; $display("FAIL start_wins_result: got %h%h want %h", h, l, e); end
  endtask

  task automatic test_reset_mid;
    int c;
    logic [31:0] h, l;
    logic d;
    logic [63:0] e;
    launch(OP_DIVU, 32'hFFFFFFFF, 32'd3, model(OP_DIVU, 32'hFFFFFFFF, 32'd3));
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    e = exp_q.pop_front();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset done: got %b want 0", done); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL midreset hilo: got %h%h want 0 (abandoned %h)", hi, lo, e); end
    @(negedge clock);
    launch(OP_MULTU, 32'd6, 32'd7, 64'h00000000_0000002A);
    collect(c, h, l, d);
    e = exp_q.pop_front();
    checks++; if (c != 32) begin errors++; $display("FAIL after_reset cycles: got %0d want 32", c); end
    checks++; if ({h, l} !== e) begin errors++; $display("FAIL after_reset result: got %h%h want %h", h, l, e); end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_control();
    test_reset_mid();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
